// File: rtl/nibble_word_packer_if.sv
// Nibble-in / word-out handshake bundle for nibble_word_packer.
// master = upstream source + downstream sink side, slave = the packer.
interface nibble_word_packer_if;
  logic [3:0]  inNibble;
  logic        inValid;
  logic        outReady;
  logic        inClear;
  logic [15:0] outData;
  logic        outValid;
  logic        inReady;
  logic [1:0]  outSel;

  modport master (
    output inNibble, inValid, inClear, inReady,
    input  outReady, outData, outValid, outSel
  );

  modport slave (
    input  inNibble, inValid, inClear, inReady,
    output outReady, outData, outValid, outSel
  );
endinterface

// File: rtl/nibble_word_packer.sv
// Reassembles four bit-reversed 4-bit symbols into a 16-bit word (inverse of the
// 16->4 nibble selector), with a separate output register so intake keeps running.
module nibble_word_packer (
  input logic                 clk,
  input logic                 resetn,
  nibble_word_packer_if.slave bus
);
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;

  logic [1:0]        cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;
  logic [NIB_W-1:0]  nib_rev_c;
  logic [WORD_W-1:0] merged_c;
  logic              accept_c;
  logic              ready_c;

  // Slot 3 may only complete a word when the output register is free or draining.
  assign ready_c   = !((cnt == 2'd3) && valid_q && !bus.inReady);
  assign accept_c  = bus.inValid && ready_c;
  assign nib_rev_c = {bus.inNibble[0], bus.inNibble[1], bus.inNibble[2], bus.inNibble[3]};

  always_comb begin
    merged_c = asm_q;
    merged_c[{cnt, 2'b00} +: NIB_W] = nib_rev_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= 2'd0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && bus.inReady)
        valid_q <= 1'b0;
      if (bus.inClear) begin
        cnt   <= 2'd0;
        asm_q <= '0;
      end else if (accept_c) begin
        if (cnt == 2'd3) begin
          // A load in the same cycle as a drain keeps outValid high.
          data_q  <= merged_c;
          valid_q <= 1'b1;
          cnt     <= 2'd0;
          asm_q   <= '0;
        end else begin
          asm_q <= merged_c;
          cnt   <= cnt + 2'd1;
        end
      end
    end
  end

  assign bus.outReady = ready_c;
  assign bus.outData  = data_q;
  assign bus.outValid = valid_q;
  assign bus.outSel   = cnt;
endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed and randomized checks of nibble_word_packer against hand-computed words
// and a small slot/bit-order reference model.
module tb_nibble_word_packer;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  nibble_word_packer_if bus ();

  nibble_word_packer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  ord [4];
  logic [3:0]  bp  [8];
  logic [3:0]  cw  [4];
  logic [15:0] exp_q [$];
  logic [3:0]  mn [4];
  int          mslot;
  int          words_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: asm[4k+j] = nibble_k[3-j]
  function automatic logic [15:0] pack4(input logic [3:0] n0, input logic [3:0] n1,
                                        input logic [3:0] n2, input logic [3:0] n3);
    logic [3:0]  n [4];
    logic [15:0] w;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    w = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        w[4*k+j] = n[k][3-j];
    return w;
  endfunction

  // The 16->4 selector this block inverts.
  function automatic logic [3:0] sel4(input logic [15:0] w, input int s);
    logic [3:0] r;
    for (int j = 0; j < 4; j++)
      r[3-j] = w[4*s+j];
    return r;
  endfunction

  task automatic send(input logic [3:0] n);
    bus.inNibble = n;
    bus.inValid  = 1'b1;
    @(posedge clk); #1;
    bus.inValid  = 1'b0;
  endtask

  task automatic run_random(input int ncyc, input bit gapped);
    logic       v;
    logic [3:0] nib;
    logic [31:0] expw;
    mslot = 0;
    for (int c = 0; c < ncyc + 8; c++) begin
      v   = (c < ncyc) ? (gapped ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      nib = 4'($urandom_range(0, 15));
      bus.inValid  = v;
      bus.inNibble = nib;
      #1;
      check("rnd_ready", 32'(bus.outReady), 32'd1);
      if (v) begin
        mn[mslot] = nib;
        mslot++;
        if (mslot == 4) begin
          exp_q.push_back(pack4(mn[0], mn[1], mn[2], mn[3]));
          mslot = 0;
        end
      end
      @(posedge clk); #1;
      check("rnd_sel", 32'(bus.outSel), 32'(mslot));
      if (bus.outValid) begin
        expw = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h1_0000;
        check("rnd_word", 32'(bus.outData), expw);
        words_seen++;
      end
    end
    bus.inValid = 1'b0;
    check("rnd_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; words_seen = 0;
    ord = '{4'h1, 4'h2, 4'h4, 4'h8};
    bp  = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hE, 4'h1, 4'h6, 4'hC};
    cw  = '{4'hA, 4'hB, 4'hC, 4'hD};
    bus.inNibble = '0; bus.inValid = 1'b0; bus.inClear = 1'b0; bus.inReady = 1'b1;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst_valid", 32'(bus.outValid), 32'd0);
    check("rst_data",  32'(bus.outData),  32'h0);
    check("rst_sel",   32'(bus.outSel),   32'd0);
    check("rst_ready", 32'(bus.outReady), 32'd1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Ordering: 1,2,4,8 -> 16'h1248
    for (int i = 0; i < 4; i++) begin
      bus.inNibble = ord[i];
      bus.inValid  = 1'b1;
      #1 check("ord_ready", 32'(bus.outReady), 32'd1);
      @(posedge clk); #1;
      if (i == 2) check("ord_early", 32'(bus.outValid), 32'd0);
    end
    bus.inValid = 1'b0;
    check("ord_valid", 32'(bus.outValid), 32'd1);
    check("ord_data",  32'(bus.outData),  32'h1248);
    for (int s = 0; s < 4; s++)
      check("ord_roundtrip", 32'(sel4(bus.outData, s)), 32'(ord[s]));
    @(posedge clk); #1;
    check("ord_one_cycle", 32'(bus.outValid), 32'd0);
    check("ord_hold",      32'(bus.outData),  32'h1248);

    // Back-pressure: words 16'h9EAC then 16'h3687
    bus.inReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.inNibble = bp[i];
      bus.inValid  = 1'b1;
      #1 check("bp_ready", 32'(bus.outReady), 32'd1);
      @(posedge clk); #1;
      if (i >= 3) begin
        check("bp_valid", 32'(bus.outValid), 32'd1);
        check("bp_w1",    32'(bus.outData),  32'h9EAC);
      end
    end
    bus.inNibble = bp[7];
    #1 check("bp_ready_low", 32'(bus.outReady), 32'd0);
    @(posedge clk); #1;
    check("bp_sel_hold", 32'(bus.outSel),  32'd3);
    check("bp_w1_hold",  32'(bus.outData), 32'h9EAC);
    bus.inReady = 1'b1;
    #1 check("bp_ready_rel", 32'(bus.outReady), 32'd1);
    @(posedge clk); #1;
    check("bp_valid2", 32'(bus.outValid), 32'd1);
    check("bp_w2",     32'(bus.outData),  32'h3687);
    check("bp_sel0",   32'(bus.outSel),   32'd0);
    bus.inValid = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", 32'(bus.outValid), 32'd0);

    // Clear with a pending word 16'hF0D4; next word A,B,C,D -> 16'hB3D5
    bus.inReady = 1'b0;
    send(4'h2); send(4'hB); send(4'h0); send(4'hF);
    send(4'h7); send(4'h7);
    check("clr_pre_sel", 32'(bus.outSel), 32'd2);
    bus.inClear = 1'b1; bus.inNibble = 4'h5; bus.inValid = 1'b1;
    @(posedge clk); #1;
    bus.inClear = 1'b0; bus.inValid = 1'b0;
    check("clr_sel",     32'(bus.outSel),   32'd0);
    check("clr_pending", 32'(bus.outValid), 32'd1);
    check("clr_data",    32'(bus.outData),  32'hF0D4);
    bus.inReady = 1'b1;
    @(posedge clk); #1;
    check("clr_drain", 32'(bus.outValid), 32'd0);
    for (int i = 0; i < 4; i++) send(cw[i]);
    check("clr_valid", 32'(bus.outValid), 32'd1);
    check("clr_word",  32'(bus.outData),  32'hB3D5);
    @(posedge clk); #1;

    // Sustained stream: 64 nibbles -> 16 words
    words_seen = 0;
    run_random(64, 1'b0);
    check("sus_words", 32'(words_seen), 32'd16);

    // Gapped input
    run_random(80, 1'b1);

    // Asynchronous reset mid-word with a pending word
    bus.inReady = 1'b0;
    for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 15)));
    #2 resetn = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.outValid), 32'd0);
    check("mrst_data",  32'(bus.outData),  32'h0);
    check("mrst_sel",   32'(bus.outSel),   32'd0);
    check("mrst_ready", 32'(bus.outReady), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.inReady = 1'b1;
    for (int i = 0; i < 4; i++) send(ord[i]);
    check("mrst_word", 32'(bus.outData), 32'h1248);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nibble_word_packer.md
# nibble_word_packer

Receive-side counterpart of the 16-bit to 4-bit nibble selector used in the ZigBee symbol path. It accepts a stream of 4-bit symbols (nibbles) over a valid/ready handshake and reassembles four consecutive nibbles into one 16-bit word, using the exact inverse of the selector's slot and bit ordering. The block sits between the despreader/symbol decision stage and the byte/word-oriented PHY receive logic. It double-buffers so that nibble intake is not stalled while a completed word waits downstream.

## Interface
- No parameters. Width is fixed: 4-bit nibble, 16-bit word, 4 slots.
- clk  input  1  single system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- inNibble  input  4  incoming symbol nibble.
- inValid  input  1  inNibble valid this cycle.
- outReady  output  1  packer can accept a nibble this cycle.
- inClear  input  1  synchronous clear of the partially assembled word.
- outData  output  16  assembled word; stable while outValid=1.
- outValid  output  1  outData holds a complete word.
- inReady  input  1  downstream accepts outData this cycle.
- outSel  output  2  slot index the next accepted nibble is written to (0..3).

## Operation
- Nibble accept: inValid && outReady on a clock edge.
- Slot mapping, the inverse of the selector: nibble in slot k (k = outSel) is written as asm[4k+j] = inNibble[3-j] for j = 0..3.
  - Slot 0 therefore occupies bits [3:0] bit-reversed, and slot 3 occupies bits [15:12] bit-reversed.
- Assembly register asm[15:0] plus slot counter cnt[1:0]; outSel = cnt.
- Accept in slots 0..2: write the nibble into asm, then cnt <= cnt+1.
- Accept in slot 3:
  - The full word (asm with slot 3 merged) is loaded into the output register.
  - outValid <= 1, cnt <= 0, asm <= 0.
- Output handshake: word consumed on outValid && inReady; outValid <= 0 unless a new word is loaded in the same cycle (load wins, outValid stays 1).
- outReady = !(cnt==3 && outValid && !inReady).
  - Slots 0..2 are always accepted, even while an output word is pending.
  - Slot 3 is accepted only if the output register is empty or is being drained in the same cycle.
- inClear (synchronous):
  - cnt <= 0, asm <= 0.
  - Any nibble accepted in the same cycle is discarded.
  - The output register and outValid are unaffected.
- Unused asm bits of a partial word are never exposed; outData changes only on a full-word load.

## Timing
- Reset (resetn=0, asynchronous): cnt=0, asm=0, outData=16'h0000, outValid=0, outSel=0.
  - outReady=1 combinationally after reset.
- Latency: outValid rises on the edge that accepts the 4th nibble, so the word is visible the cycle after that nibble is presented.
- Throughput: 1 nibble/cycle sustained, i.e. 1 word per 4 cycles, provided downstream drains each word within 3 cycles of outValid.
- outReady is combinational from cnt, outValid and inReady; there is no path from inValid to outReady.
- outData and outValid are registered; no combinational path from inputs.
- Reset deasserted mid-word: the partial word is lost and the next accepted nibble goes to slot 0.
- Gaps (inValid=0) hold all state; there is no timeout.

## Test plan
- Reset/idle:
  - Stimulus: assert resetn=0 mid-stream.
  - Required response: outValid=0, outData=0, outSel=0, outReady=1 immediately, without waiting for a clock edge.
- Ordering:
  - Stimulus: nibbles 4'h1, 4'h2, 4'h4, 4'h8 back-to-back, with inReady=1.
  - Required response: outData=16'h1248 and outValid=1 for exactly 1 cycle, one cycle after the 4th nibble.
  - Round-trip check: feeding outData into the 4:1 selector with sel 0..3 must return 1, 2, 4, 8.
- Back-pressure:
  - Stimulus: inReady=0, stream 8 nibbles.
  - Required response: the first word is held stable; outReady drops to 0 at cnt=3.
  - Release: asserting inReady=1 drains word 1 and accepts nibble 8 in the same cycle, and outValid stays 1 with word 2.
- Sustained stream:
  - Stimulus: 64 random nibbles, inValid=1 continuously, inReady=1.
  - Required response: 16 words, each matching the reference model; outReady never 0.
- Clear:
  - Stimulus: 2 nibbles, then inClear=1 together with a valid nibble, then nibbles A, B, C, D.
  - Required response: the clear-cycle nibble is dropped; the next word is built from A, B, C, D only; a word pending in the output register survives the clear.
- Gapped input:
  - Stimulus: inValid toggling randomly.
  - Required response: words match the reference model; outSel increments only on accepted nibbles.
